// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter: shares one byte-wide RAM port between instruction fetch and    |
// | data load/store; serialises 1/2/4-byte accesses little-endian.              |
// | Optional macro: ARB_ROUND_ROBIN_EN (alternate grants on contention).        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [2:0]            dm_funct3,
  input  logic [31:0]           dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic                  dm_ack,
  output logic [31:0]           dm_rdata,
  output logic                  stallreq,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [2:0]              last_idx;
  logic                    cur_if;
  logic [2:0]              cur_f3;
  logic [RAM_ADDR_W-1:0]   base;
  logic [31:0]             wbuf;
  logic [31:0]             rbuf;

  logic                    grant_dm;
  logic                    dm_legal;
  logic [2:0]              req_last;
  logic [1:0]              rsel;
  logic [1:0]              wsel;
  logic [31:0]             merged;
  logic [31:0]             ext;
  logic [RAM_ADDR_W-1:0]   next_addr;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^{dm_addr[31:RAM_ADDR_W], if_addr[31:RAM_ADDR_W]};
  assign stallreq = dm_req & ~dm_ack;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = IF, 1 = DM
  assign grant_dm = dm_req & (~if_req | ~last_grant);
`else
  assign grant_dm = dm_req;
`endif

  // Loads: 0,1,2,4,5 legal; stores: 0..2 legal
  assign dm_legal = dm_we ? (dm_funct3 <= 3'd2)
                          : ((dm_funct3[1:0] != 2'b11) && (dm_funct3 != 3'd6));

  always_comb begin
    req_last = 3'd3;
    case (dm_funct3[1:0])
      2'd0:    req_last = 3'd0;
      2'd1:    req_last = 3'd1;
      default: req_last = 3'd3;
    endcase
  end

  // In RD, count value c captures byte c-1 (count 4 wraps to lane 3)
  assign rsel      = cnt[1:0] - 2'd1;
  assign wsel      = cnt[1:0] + 2'd1;
  assign next_addr = base + RAM_ADDR_W'(cnt + 3'd1);

  always_comb begin
    merged = rbuf;
    merged[{rsel, 3'b000} +: 8] = ram_rdata;
  end

  always_comb begin
    ext = merged;
    case (cur_f3)
      3'd0:    ext = {{24{merged[7]}}, merged[7:0]};
      3'd1:    ext = {{16{merged[15]}}, merged[15:0]};
      3'd4:    ext = {24'd0, merged[7:0]};
      3'd5:    ext = {16'd0, merged[15:0]};
      default: ext = merged;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_wdata <= '0;
      cnt       <= '0;
      last_idx  <= '0;
      cur_if    <= 1'b0;
      cur_f3    <= '0;
      base      <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      ram_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          rbuf <= '0;
          if (grant_dm) begin
            cur_if   <= 1'b0;
            cur_f3   <= dm_funct3;
            base     <= dm_addr[RAM_ADDR_W-1:0];
            wbuf     <= dm_wdata;
            last_idx <= req_last;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
            if (!dm_legal) begin
              dm_ack <= 1'b1;
              if (!dm_we) dm_rdata <= '0;
              state  <= S_DONE;
            end else begin
              ram_addr <= dm_addr[RAM_ADDR_W-1:0];
              if (dm_we) begin
                ram_wr    <= 1'b1;
                ram_wdata <= dm_wdata[7:0];
                state     <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end else if (if_req) begin
            cur_if   <= 1'b1;
            cur_f3   <= 3'd2;
            base     <= if_addr[RAM_ADDR_W-1:0];
            last_idx <= 3'd3;
            ram_addr <= if_addr[RAM_ADDR_W-1:0];
            state    <= S_RD;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
          end
        end
        S_RD: begin
          if (cnt < last_idx) ram_addr <= next_addr;
          if (cnt != 3'd0) rbuf <= merged;
          if (cnt == last_idx + 3'd1) begin
            if (cur_if) begin
              if_ack   <= 1'b1;
              if_rdata <= merged;
            end else begin
              dm_ack   <= 1'b1;
              dm_rdata <= ext;
            end
            state <= S_DONE;
          end
          cnt <= cnt + 3'd1;
        end
        S_WR: begin
          if (cnt < last_idx) begin
            ram_addr  <= next_addr;
            ram_wr    <= 1'b1;
            ram_wdata <= wbuf[{wsel, 3'b000} +: 8];
          end else begin
            dm_ack <= 1'b1;
            state  <= S_DONE;
          end
          cnt <= cnt + 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
